// File: rtl/clk_enable_gen.sv
// Multi-channel programmable clock-enable generator: per-channel divide-by-div tick/square outputs, optionally cascaded.
// Latency: tick is combinational from registered count (same cycle as terminal count); sq/ch_out square edge 1 cycle after tick.
// Backpressure: none; global enable and per-channel ch_en freeze counting, sync restarts every channel's phase.
//
// Ports:
//   clk, reset          system clock (rising edge) and asynchronous active-high reset
//   enable, ch_en       global and per-channel count enables
//   sync                synchronous restart of all counters and square outputs
//   cfg_we/cfg_ch/...   single-cycle configuration write of div, mode, casc for one channel
//   tick                one-cycle terminal-count pulse per channel
//   ch_out              per-channel output: tick (mode 0) or square wave (mode 1)
module clk_enable_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 25,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sync,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic              cfg_casc,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] ch_out
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q;
    logic             casc_q;
    logic             sq_q;
    logic             cfg_sel;
    logic             prev_tick;
    logic             adv;
    logic             running;
    logic             tick_i;

    // Channel 0 has no upstream neighbour, so its cascade bit has no effect:
    // tying the upstream tick high makes adv reduce to enable & ch_en.
    if (i == 0) begin : g_head
      assign prev_tick = 1'b1;
    end else begin : g_link
      // Reference the neighbour's local tick rather than the packed output
      // vector so the ripple chain is not a self-referencing bus.
      assign prev_tick = g_ch[i-1].tick_i;
    end

    // Out-of-range channel indices match no channel, so such writes are dropped.
    assign cfg_sel = cfg_we && (int'(cfg_ch) == i);

    assign adv     = enable & ch_en[i] & (~casc_q | prev_tick);
    assign running = (div_q != '0);

    // div == 0 parks the channel; the running term also keeps div-1 from
    // wrapping to an all-ones terminal count.
    assign tick_i  = ~reset & adv & running & (cnt_q == (div_q - ONE));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        div_q  <= DIV_RST;
        mode_q <= 1'b0;
        casc_q <= 1'b0;
        cnt_q  <= '0;
        sq_q   <= 1'b0;
      end else begin
        if (cfg_sel) begin
          div_q  <= cfg_div;
          mode_q <= cfg_mode;
          casc_q <= cfg_casc;
        end
        // A restart (global sync or a reconfigure of this channel) discards
        // the partially elapsed period and takes priority over counting.
        if (sync || cfg_sel) begin
          cnt_q <= '0;
          sq_q  <= 1'b0;
        end else if (tick_i) begin
          cnt_q <= '0;
          sq_q  <= ~sq_q;
        end else if (adv && running) begin
          cnt_q <= cnt_q + ONE;
        end
      end
    end

    assign tick[i]   = tick_i;
    assign ch_out[i] = ~reset & (mode_q ? sq_q : tick_i);
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
module tb_clk_enable_gen;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       sync;
  logic [3:0] ch_en;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_mode;
  logic       cfg_casc;
  logic [3:0] tick;
  logic [3:0] ch_out;

  // Second, 3-channel instance: its 2-bit channel index can address a
  // nonexistent channel 3, which exercises the out-of-range write case.
  logic [2:0] ch_en_b;
  logic       cfg_we_b;
  logic [1:0] cfg_ch_b;
  logic [7:0] cfg_div_b;
  logic       cfg_mode_b;
  logic       cfg_casc_b;
  logic [2:0] tick_b;
  logic [2:0] ch_out_b;

  clk_enable_gen #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(25)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync), .ch_en(ch_en),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .cfg_casc(cfg_casc), .tick(tick), .ch_out(ch_out)
  );

  clk_enable_gen #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(25)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync), .ch_en(ch_en_b),
    .cfg_we(cfg_we_b), .cfg_ch(cfg_ch_b), .cfg_div(cfg_div_b), .cfg_mode(cfg_mode_b),
    .cfg_casc(cfg_casc_b), .tick(tick_b), .ch_out(ch_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         b;
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Monitor: sample on the falling edge, pop every expectation due now.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] at;
    logic [3:0] ao;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e  = sb.pop_front();
      at = e.b ? {1'b0, tick_b}   : tick;
      ao = e.b ? {1'b0, ch_out_b} : ch_out;
      checks++;
      if (e.cyc != cyc || ((at ^ e.t) & e.m) != 4'b0 || ((ao ^ e.o) & e.m) != 4'b0) begin
        failures++;
        $display("FAIL %s cyc=%0d due=%0d tick=%b ch_out=%b expected tick=%b ch_out=%b mask=%b",
                 e.tag, cyc, e.cyc, at, ao, e.t, e.o, e.m);
      end
    end
  end

  initial begin
    #200000;
    checks++;
    failures++;
    $display("FAIL watchdog_timeout cyc=%0d pending=%0d", cyc, sb.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic expect_at(input int c, input bit b, input logic [3:0] m,
                           input logic [3:0] t, input logic [3:0] o, input string tag);
    exp_t e;
    e.cyc = c; e.b = b; e.m = m; e.t = t; e.o = o; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_now(input logic [3:0] t, input logic [3:0] o, input string tag);
    checks++;
    if (tick !== t || ch_out !== o) begin
      failures++;
      $display("FAIL %s cyc=%0d tick=%b ch_out=%b expected tick=%b ch_out=%b",
               tag, cyc, tick, ch_out, t, o);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [7:0] d, input logic m, input logic c);
    cfg_we = 1'b1; cfg_ch = ch; cfg_div = d; cfg_mode = m; cfg_casc = c;
  endtask

  initial begin
    int         base;
    int         e;
    logic       t0;
    logic       t1;
    logic [3:0] tv;
    logic [3:0] ov;

    reset = 1'b1; enable = 1'b1; sync = 1'b0; ch_en = 4'hF;
    cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0; cfg_mode = 1'b0; cfg_casc = 1'b0;
    ch_en_b = 3'b111; cfg_we_b = 1'b0; cfg_ch_b = 2'd0; cfg_div_b = 8'd0;
    cfg_mode_b = 1'b0; cfg_casc_b = 1'b0;

    // Reset state, then default divide-by-25 on all channels.
    step(3);
    check_now(4'h0, 4'h0, "reset_state_direct");
    expect_at(cyc, 1'b0, 4'hF, 4'h0, 4'h0, "reset_outputs");
    step(1);
    reset = 1'b0;
    base = cyc;
    for (int j = 0; j < 60; j++) begin
      tv = (j % 25 == 24) ? 4'hF : 4'h0;
      expect_at(base + j, 1'b0, 4'hF, tv, tv, "default_div25");
    end
    step(60);

    // ch1 div=4 square mode, realigned by sync in the same cycle.
    sync = 1'b1; cfg(2'd1, 8'd4, 1'b1, 1'b0);
    step(1);
    sync = 1'b0; cfg_we = 1'b0;
    base = cyc;
    for (int j = 0; j < 50; j++) begin
      t0 = (j % 25 == 24);
      tv = {t0, t0, (j % 4 == 3), t0};
      ov = {t0, t0, ((j / 4) % 2 == 1), t0};
      expect_at(base + j, 1'b0, 4'hF, tv, ov, "ch1_square_div4");
    end
    step(50);

    // ch0 div=25, ch1 div=4 cascaded; enable low for 10 cycles mid-run.
    sync = 1'b1; cfg(2'd0, 8'd25, 1'b0, 1'b0);
    step(1);
    cfg(2'd1, 8'd4, 1'b0, 1'b1);
    step(1);
    sync = 1'b0; cfg_we = 1'b0;
    base = cyc;
    for (int j = 0; j < 220; j++) begin
      e  = (j < 110) ? j : ((j < 120) ? -1 : j - 10);
      t0 = (e >= 0) && (e % 25 == 24);
      t1 = (e >= 0) && (e % 100 == 99);
      tv = {t0, t0, t1, t0};
      expect_at(base + j, 1'b0, 4'hF, tv, tv, "cascade_div100");
    end
    step(110);
    enable = 1'b0;
    step(10);
    enable = 1'b1;
    step(100);

    // ch2 div=0 stays silent, then div=1 ticks every cycle.
    sync = 1'b1; cfg(2'd2, 8'd0, 1'b0, 1'b0);
    step(1);
    sync = 1'b0; cfg_we = 1'b0;
    base = cyc;
    for (int j = 0; j < 200; j++)
      expect_at(base + j, 1'b0, 4'b0100, 4'h0, 4'h0, "ch2_div0_stopped");
    step(200);
    cfg(2'd2, 8'd1, 1'b0, 1'b0);
    step(1);
    cfg_we = 1'b0;
    base = cyc;
    for (int j = 0; j < 10; j++)
      expect_at(base + j, 1'b0, 4'b0100, 4'b0100, 4'b0100, "ch2_div1");
    step(10);

    // sync plus write to ch3 (div=3) while ch0 is mid-period at cnt=12.
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    base = cyc;
    for (int j = 0; j <= 12; j++)
      expect_at(base + j, 1'b0, 4'hF, 4'b0100, 4'b0100, "pre_sync_midperiod");
    step(12);
    sync = 1'b1; cfg(2'd3, 8'd3, 1'b0, 1'b0);
    step(1);
    sync = 1'b0; cfg_we = 1'b0;
    base = cyc;
    for (int j = 0; j < 60; j++) begin
      tv = {(j % 3 == 2), 1'b1, 1'b0, (j % 25 == 24)};
      expect_at(base + j, 1'b0, 4'hF, tv, tv, "sync_with_cfg_ch3");
    end
    step(60);

    // Out-of-range write on the 3-channel instance must change nothing.
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    base = cyc;
    for (int j = 0; j < 60; j++) begin
      tv = (j % 25 == 24) ? 4'b0111 : 4'h0;
      expect_at(base + j, 1'b1, 4'b0111, tv, tv, "out_of_range_write");
    end
    step(5);
    cfg_we_b = 1'b1; cfg_ch_b = 2'd3; cfg_div_b = 8'd2; cfg_mode_b = 1'b1; cfg_casc_b = 1'b0;
    step(1);
    cfg_we_b = 1'b0;
    step(54);

    // Asynchronous reset mid-count (ch2 is ticking every cycle here).
    reset = 1'b1;
    #1;
    check_now(4'h0, 4'h0, "async_reset_direct");
    expect_at(cyc, 1'b0, 4'hF, 4'h0, 4'h0, "async_reset_immediate");
    step(2);
    reset = 1'b0;
    base = cyc;
    for (int j = 0; j < 30; j++) begin
      tv = (j % 25 == 24) ? 4'hF : 4'h0;
      expect_at(base + j, 1'b0, 4'hF, tv, tv, "div_restored_after_reset");
    end
    step(31);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL expectations_expired pending=%0d cyc=%0d", sb.size(), cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
